// File: rtl/mips_tlb_pkg.sv
// Shared TLB entry layout, segment codes and the per-port translation rule.
// Entry word: {vpn2[18:0], asid[7:0], g, lo0[24:0], lo1[24:0]}, lo = {pfn[19:0], c[2:0], d, v}.
package mips_tlb_pkg;

    localparam int TLB_ENTRY_W = 78;
    localparam int VPN2_HI     = 77;
    localparam int VPN2_LO     = 59;
    localparam int ASID_HI     = 58;
    localparam int ASID_LO     = 51;
    localparam int G_BIT       = 50;
    localparam int LO0_HI      = 49;
    localparam int LO0_LO      = 25;
    localparam int LO1_HI      = 24;
    localparam int LO1_LO      = 0;
    localparam int LO_W        = 25;
    localparam int TAG_W       = VPN2_HI - G_BIT + 1;

    localparam int PFN_HI      = 24;
    localparam int PFN_LO      = 5;
    localparam int D_BIT       = 1;
    localparam int V_BIT       = 0;

    localparam logic [2:0] KSEG0 = 3'b100;
    localparam logic [2:0] KSEG1 = 3'b101;

    typedef struct packed {
        logic [31:0] paddr;
        logic        refill;
        logic        invalid;
        logic        modified;
    } xlat_t;

    // Fault flags are mutually exclusive: refill beats invalid beats modified.
    function automatic xlat_t translate(input logic [31:0]     va,
                                        input logic            hit,
                                        input logic [LO_W-1:0] lo,
                                        input logic            store);
        xlat_t r;
        r = '0;
        if (va[31:29] == KSEG0 || va[31:29] == KSEG1) begin
            r.paddr = {3'b000, va[28:0]};
        end else begin
            r.paddr = {lo[PFN_HI:PFN_LO], va[11:0]};
            if (!hit)
                r.refill = 1'b1;
            else if (!lo[V_BIT])
                r.invalid = 1'b1;
            else if (store && !lo[D_BIT])
                r.modified = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mips_tlb_match.sv
// Associative tag compare of one {vpn2, asid} key against every TLB entry.
// The lowest matching index wins when several entries hit.
module tlb_match
    import mips_tlb_pkg::*;
#(
    parameter  int TLBNUM = 16,
    localparam int IW     = $clog2(TLBNUM)
) (
    input  logic [TLBNUM-1:0][TAG_W-1:0] i_tags,
    input  logic [18:0]                  i_vpn2,
    input  logic [7:0]                   i_asid,
    output logic [TLBNUM-1:0]            o_hit,
    output logic [IW-1:0]                o_idx,
    output logic                         o_any
);

    // Tag layout: {vpn2[18:0], asid[7:0], g}
    for (genvar g = 0; g < TLBNUM; g++) begin : g_lane
        assign o_hit[g] = (i_tags[g][TAG_W-1:9] == i_vpn2) &&
                          (i_tags[g][0] || (i_tags[g][8:1] == i_asid));
    end

    always_comb begin
        o_idx = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (o_hit[i])
                o_idx = IW'(i);
        end
    end

    assign o_any = |o_hit;

endmodule

// File: rtl/mips_tlb.sv
// Fully-associative joint TLB: CP0 TLBWI/TLBR/TLBP plus fetch (s0) and data (s1)
// translation ports, all with one-cycle registered responses and no back-pressure.
module mips_tlb
    import mips_tlb_pkg::*;
#(
    parameter  int TLBNUM = 16,
    localparam int IW     = $clog2(TLBNUM)
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   tlbwi_en,
    input  logic [IW-1:0]          tlbwi_index,
    input  logic [TLB_ENTRY_W-1:0] tlbwi_entry,

    input  logic                   tlbr_req,
    input  logic [IW-1:0]          tlbr_index,
    output logic                   tlbr_wen,
    output logic [TLB_ENTRY_W-1:0] tlbr_entry,

    input  logic                   tlbp_req,
    input  logic [31:0]            tlbp_entryhi,
    output logic                   tlbp_valid,
    output logic [31:0]            tlbp_index,

    input  logic                   s0_req,
    input  logic [31:0]            s0_vaddr,
    input  logic [7:0]             s0_asid,
    output logic                   s0_valid,
    output logic [31:0]            s0_paddr,
    output logic                   s0_refill,
    output logic                   s0_invalid,

    input  logic                   s1_req,
    input  logic [31:0]            s1_vaddr,
    input  logic [7:0]             s1_asid,
    input  logic                   s1_store,
    output logic                   s1_valid,
    output logic [31:0]            s1_paddr,
    output logic                   s1_refill,
    output logic                   s1_invalid,
    output logic                   s1_modified
);

    logic [TLBNUM-1:0][TLB_ENTRY_W-1:0] r_tlb;
    logic [TLBNUM-1:0][TAG_W-1:0]       w_tags;
    logic [2:0][18:0]                   w_q_vpn2;
    logic [2:0][7:0]                    w_q_asid;
    logic [2:0][TLBNUM-1:0]             w_m_hit_unused;
    logic [2:0][IW-1:0]                 w_m_idx;
    logic [2:0]                         w_m_any;
    logic [TLB_ENTRY_W-1:0]             w_ent0, w_ent1;
    logic [LO_W-1:0]                    w_lo0, w_lo1;
    xlat_t                              w_x0, w_x1;
    logic                               w_unused;

    // Writes land at the edge; everything sampled on that edge still sees old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_tlb <= '0;
        else if (tlbwi_en)
            r_tlb[tlbwi_index] <= tlbwi_entry;
    end

    for (genvar g = 0; g < TLBNUM; g++) begin : g_tag
        assign w_tags[g] = r_tlb[g][VPN2_HI:G_BIT];
    end

    // Port 0 = s0, 1 = s1, 2 = probe
    assign w_q_vpn2 = {tlbp_entryhi[31:13], s1_vaddr[31:13], s0_vaddr[31:13]};
    assign w_q_asid = {tlbp_entryhi[7:0], s1_asid, s0_asid};

    for (genvar p = 0; p < 3; p++) begin : g_port
        tlb_match #(.TLBNUM(TLBNUM)) u_match (
            .i_tags (w_tags),
            .i_vpn2 (w_q_vpn2[p]),
            .i_asid (w_q_asid[p]),
            .o_hit  (w_m_hit_unused[p]),
            .o_idx  (w_m_idx[p]),
            .o_any  (w_m_any[p])
        );
    end

    assign w_ent0 = r_tlb[w_m_idx[0]];
    assign w_ent1 = r_tlb[w_m_idx[1]];
    assign w_lo0  = s0_vaddr[12] ? w_ent0[LO1_HI:LO1_LO] : w_ent0[LO0_HI:LO0_LO];
    assign w_lo1  = s1_vaddr[12] ? w_ent1[LO1_HI:LO1_LO] : w_ent1[LO0_HI:LO0_LO];
    assign w_x0   = translate(s0_vaddr, w_m_any[0], w_lo0, 1'b0);
    assign w_x1   = translate(s1_vaddr, w_m_any[1], w_lo1, s1_store);

    assign w_unused = ^{tlbp_entryhi[12:8], w_x0.modified};

    // Valids pulse for one cycle; data only reloads on a new request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tlbr_wen    <= 1'b0;
            tlbr_entry  <= '0;
            tlbp_valid  <= 1'b0;
            tlbp_index  <= '0;
            s0_valid    <= 1'b0;
            s0_paddr    <= '0;
            s0_refill   <= 1'b0;
            s0_invalid  <= 1'b0;
            s1_valid    <= 1'b0;
            s1_paddr    <= '0;
            s1_refill   <= 1'b0;
            s1_invalid  <= 1'b0;
            s1_modified <= 1'b0;
        end else begin
            tlbr_wen   <= tlbr_req;
            tlbp_valid <= tlbp_req;
            s0_valid   <= s0_req;
            s1_valid   <= s1_req;
            if (tlbr_req)
                tlbr_entry <= r_tlb[tlbr_index];
            if (tlbp_req)
                tlbp_index <= {~w_m_any[2], {(31-IW){1'b0}}, w_m_idx[2]};
            if (s0_req) begin
                s0_paddr   <= w_x0.paddr;
                s0_refill  <= w_x0.refill;
                s0_invalid <= w_x0.invalid;
            end
            if (s1_req) begin
                s1_paddr    <= w_x1.paddr;
                s1_refill   <= w_x1.refill;
                s1_invalid  <= w_x1.invalid;
                s1_modified <= w_x1.modified;
            end
        end
    end

endmodule

// File: tb/tb_mips_tlb.sv
// Self-checking bench for mips_tlb: directed vector table, random traffic against a
// scan-the-array reference model, and a reset-while-in-flight sequence.
module tb_mips_tlb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tlbwi_en;
    logic [3:0]  tlbwi_index;
    logic [77:0] tlbwi_entry;
    logic        tlbr_req;
    logic [3:0]  tlbr_index;
    logic        tlbr_wen;
    logic [77:0] tlbr_entry;
    logic        tlbp_req;
    logic [31:0] tlbp_entryhi;
    logic        tlbp_valid;
    logic [31:0] tlbp_index;
    logic        s0_req, s0_valid, s0_refill, s0_invalid;
    logic [31:0] s0_vaddr, s0_paddr;
    logic [7:0]  s0_asid;
    logic        s1_req, s1_store, s1_valid, s1_refill, s1_invalid, s1_modified;
    logic [31:0] s1_vaddr, s1_paddr;
    logic [7:0]  s1_asid;

    mips_tlb #(.TLBNUM(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .tlbwi_en(tlbwi_en), .tlbwi_index(tlbwi_index), .tlbwi_entry(tlbwi_entry),
        .tlbr_req(tlbr_req), .tlbr_index(tlbr_index), .tlbr_wen(tlbr_wen), .tlbr_entry(tlbr_entry),
        .tlbp_req(tlbp_req), .tlbp_entryhi(tlbp_entryhi), .tlbp_valid(tlbp_valid), .tlbp_index(tlbp_index),
        .s0_req(s0_req), .s0_vaddr(s0_vaddr), .s0_asid(s0_asid), .s0_valid(s0_valid),
        .s0_paddr(s0_paddr), .s0_refill(s0_refill), .s0_invalid(s0_invalid),
        .s1_req(s1_req), .s1_vaddr(s1_vaddr), .s1_asid(s1_asid), .s1_store(s1_store),
        .s1_valid(s1_valid), .s1_paddr(s1_paddr), .s1_refill(s1_refill),
        .s1_invalid(s1_invalid), .s1_modified(s1_modified)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;   logic [3:0]  widx; logic [77:0] went;
        logic        s0;   logic [31:0] va0;  logic [7:0]  as0;
        logic        s1;   logic [31:0] va1;  logic [7:0]  as1;  logic st1;
        logic        p;    logic [31:0] hi;
        logic        r;    logic [3:0]  ridx;
    } stim_t;

    // Fault codes: 0 none, 1 refill, 2 invalid, 3 modified
    typedef struct {
        stim_t       s;
        logic [31:0] pa0;  int f0;
        logic [31:0] pa1;  int f1;
        logic [31:0] pidx;
        logic [77:0] rent;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [77:0] m_tlb [16];

    function automatic logic [77:0] mk(input logic [18:0] vpn2, input logic [7:0] asid, input logic g,
                                       input logic [19:0] pfn0, input logic d0, input logic v0,
                                       input logic [19:0] pfn1, input logic d1, input logic v1);
        return {vpn2, asid, g, pfn0, 3'd3, d0, v0, pfn1, 3'd3, d1, v1};
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{we:0, widx:0, went:0, s0:0, va0:0, as0:0, s1:0, va1:0, as1:0, st1:0,
              p:0, hi:0, r:0, ridx:0};
        return s;
    endfunction

    function automatic int m_find(input logic [18:0] vpn2, input logic [7:0] asid);
        for (int i = 0; i < 16; i++) begin
            logic [77:0] e;
            e = m_tlb[i];
            if (e[77:59] == vpn2 && (e[50] || e[58:51] == asid))
                return i;
        end
        return -1;
    endfunction

    task automatic m_xlat(input logic [31:0] va, input logic [7:0] asid, input logic store,
                          output logic [31:0] pa, output int f);
        int i;
        logic [77:0] e;
        logic [24:0] lo;
        pa = 0;
        f = 0;
        if (va[31:30] == 2'b10) begin
            pa = va & 32'h1FFF_FFFF;
        end else begin
            i = m_find(va[31:13], asid);
            if (i < 0) begin
                f = 1;
            end else begin
                e  = m_tlb[i];
                lo = va[12] ? e[24:0] : e[49:25];
                pa = {lo[24:5], va[11:0]};
                if (!lo[0])               f = 2;
                else if (store && !lo[1]) f = 3;
            end
        end
    endtask

    function automatic int fcode(input logic r, input logic i, input logic m);
        case ({r, i, m})
            3'b000:  return 0;
            3'b100:  return 1;
            3'b010:  return 2;
            3'b001:  return 3;
            default: return 7;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [77:0] act, input logic [77:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input stim_t s);
        tlbwi_en = s.we;  tlbwi_index = s.widx; tlbwi_entry = s.went;
        s0_req = s.s0;    s0_vaddr = s.va0;     s0_asid = s.as0;
        s1_req = s.s1;    s1_vaddr = s.va1;     s1_asid = s.as1;  s1_store = s.st1;
        tlbp_req = s.p;   tlbp_entryhi = s.hi;
        tlbr_req = s.r;   tlbr_index = s.ridx;
    endtask

    // One cycle: drive at negedge, model answers from pre-write contents, check next negedge.
    task automatic step(input stim_t s);
        logic [31:0] pa0, pa1, pidx;
        logic [77:0] rent;
        int f0, f1, pi;
        m_xlat(s.va0, s.as0, 1'b0, pa0, f0);
        m_xlat(s.va1, s.as1, s.st1, pa1, f1);
        pi   = m_find(s.hi[31:13], s.hi[7:0]);
        pidx = (pi < 0) ? 32'h8000_0000 : 32'(pi);
        rent = m_tlb[s.ridx];
        drive(s);
        @(posedge clk);
        if (s.we) m_tlb[s.widx] = s.went;
        @(negedge clk);
        chk("s0_valid", s0_valid, s.s0);
        chk("s1_valid", s1_valid, s.s1);
        chk("tlbp_valid", tlbp_valid, s.p);
        chk("tlbr_wen", tlbr_wen, s.r);
        if (s.s0) begin
            chk("s0_fault", fcode(s0_refill, s0_invalid, 1'b0), f0);
            if (f0 != 1) chk("s0_paddr", s0_paddr, pa0);
        end
        if (s.s1) begin
            chk("s1_fault", fcode(s1_refill, s1_invalid, s1_modified), f1);
            if (f1 != 1) chk("s1_paddr", s1_paddr, pa1);
        end
        if (s.p) chk("tlbp_index", tlbp_index, pidx);
        if (s.r) chk("tlbr_entry", tlbr_entry, rent);
    endtask

    vec_t        tv[$];
    vec_t        v;
    stim_t       s;
    logic [77:0] e3, e3b, e3c, e1;

    initial begin
        e3  = mk(19'h1, 8'd5, 1'b0, 20'h12345, 1'b1, 1'b1, 20'h54321, 1'b0, 1'b0);
        e3b = mk(19'h1, 8'd5, 1'b1, 20'h12345, 1'b0, 1'b1, 20'h54321, 1'b0, 1'b0);
        e3c = mk(19'h1, 8'd9, 1'b1, 20'h00777, 1'b1, 1'b1, 20'h00888, 1'b1, 1'b1);
        e1  = mk(19'h1, 8'd5, 1'b0, 20'h0AAAA, 1'b1, 1'b1, 20'h0BBBB, 1'b1, 1'b1);

        // Empty TLB: miss, no-match probe (asid 1), kseg bypass. Cleared entries are
        // real vpn2=0/asid=0 entries, so a probe of entryhi=0 finds index 0.
        v = '{s:idle(), pa0:0, f0:0, pa1:0, f1:0, pidx:0, rent:0};
        v.s.s0 = 1; v.s.va0 = 32'h0000_1000; v.s.as0 = 8'd1; v.f0 = 1;
        v.s.p = 1; v.s.hi = 32'h0000_0001; v.pidx = 32'h8000_0000;
        tv.push_back(v);
        v = '{s:idle(), pa0:0, f0:0, pa1:0, f1:0, pidx:0, rent:0};
        v.s.s0 = 1; v.s.va0 = 32'hBFC0_0000; v.s.as0 = 8'd1; v.pa0 = 32'h1FC0_0000;
        v.s.s1 = 1; v.s.va1 = 32'h8000_1234; v.s.as1 = 8'd1; v.s.st1 = 1; v.pa1 = 32'h0000_1234;
        v.s.p = 1; v.s.hi = 32'h0; v.pidx = 32'h0;
        tv.push_back(v);
        v = '{s:idle(), pa0:0, f0:0, pa1:0, f1:0, pidx:0, rent:0};
        v.s.we = 1; v.s.widx = 4'd3; v.s.went = e3;
        tv.push_back(v);
        v = '{s:idle(), pa0:0, f0:0, pa1:0, f1:0, pidx:0, rent:0};
        v.s.s0 = 1; v.s.va0 = 32'h0000_2ABC; v.s.as0 = 8'd5; v.pa0 = 32'h1234_5ABC;
        v.s.s1 = 1; v.s.va1 = 32'h0000_3ABC; v.s.as1 = 8'd5; v.f1 = 2; v.pa1 = 32'h5432_1ABC;
        tv.push_back(v);
        v = '{s:idle(), pa0:0, f0:0, pa1:0, f1:0, pidx:0, rent:0};
        v.s.s0 = 1; v.s.va0 = 32'h0000_2ABC; v.s.as0 = 8'd6; v.f0 = 1;
        v.s.p = 1; v.s.hi = 32'h0000_2005; v.pidx = 32'h0000_0003;
        tv.push_back(v);
        // Rewrite idx3 as global with d0=0; same-edge lookup and read see the old entry.
        v = '{s:idle(), pa0:0, f0:0, pa1:0, f1:0, pidx:0, rent:0};
        v.s.we = 1; v.s.widx = 4'd3; v.s.went = e3b;
        v.s.s0 = 1; v.s.va0 = 32'h0000_2ABC; v.s.as0 = 8'd6; v.f0 = 1;
        v.s.r = 1; v.s.ridx = 4'd3; v.rent = e3;
        tv.push_back(v);
        v = '{s:idle(), pa0:0, f0:0, pa1:0, f1:0, pidx:0, rent:0};
        v.s.s0 = 1; v.s.va0 = 32'h0000_2ABC; v.s.as0 = 8'd6; v.pa0 = 32'h1234_5ABC;
        v.s.s1 = 1; v.s.va1 = 32'h0000_2ABC; v.s.as1 = 8'd6; v.s.st1 = 1; v.f1 = 3; v.pa1 = 32'h1234_5ABC;
        v.s.r = 1; v.s.ridx = 4'd3; v.rent = e3b;
        tv.push_back(v);
        v = '{s:idle(), pa0:0, f0:0, pa1:0, f1:0, pidx:0, rent:0};
        v.s.we = 1; v.s.widx = 4'd1; v.s.went = e1;
        tv.push_back(v);
        // Duplicate match idx1/idx3: lowest index wins.
        v = '{s:idle(), pa0:0, f0:0, pa1:0, f1:0, pidx:0, rent:0};
        v.s.p = 1; v.s.hi = 32'h0000_2005; v.pidx = 32'h0000_0001;
        v.s.s0 = 1; v.s.va0 = 32'h0000_2ABC; v.s.as0 = 8'd5; v.pa0 = 32'h0AAA_AABC;
        v.s.s1 = 1; v.s.va1 = 32'h0000_3ABC; v.s.as1 = 8'd6; v.s.st1 = 1; v.f1 = 2; v.pa1 = 32'h5432_1ABC;
        tv.push_back(v);
        v = '{s:idle(), pa0:0, f0:0, pa1:0, f1:0, pidx:0, rent:0};
        v.s.s1 = 1; v.s.va1 = 32'hA000_0010; v.s.as1 = 8'd0; v.s.st1 = 1; v.pa1 = 32'h0000_0010;
        v.s.we = 1; v.s.widx = 4'd3; v.s.went = e3c;
        v.s.r = 1; v.s.ridx = 4'd3; v.rent = e3b;
        tv.push_back(v);
        v = '{s:idle(), pa0:0, f0:0, pa1:0, f1:0, pidx:0, rent:0};
        v.s.r = 1; v.s.ridx = 4'd3; v.rent = e3c;
        tv.push_back(v);

        rst_n = 1'b0;
        drive(idle());
        for (int i = 0; i < 16; i++) m_tlb[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_s0_valid", s0_valid, 1'b0);
        chk("rst_s1_valid", s1_valid, 1'b0);
        chk("rst_tlbp_valid", tlbp_valid, 1'b0);
        chk("rst_tlbp_index", tlbp_index, 32'h0);
        chk("rst_tlbr_wen", tlbr_wen, 1'b0);
        chk("rst_tlbr_entry", tlbr_entry, 78'h0);
        chk("rst_s0_paddr", s0_paddr, 32'h0);
        chk("rst_s1_faults", {s1_refill, s1_invalid, s1_modified}, 3'b000);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tv[k]) begin
            step(tv[k].s);
            if (tv[k].s.s0) begin
                chk($sformatf("vec%0d_s0_fault", k), fcode(s0_refill, s0_invalid, 1'b0), tv[k].f0);
                if (tv[k].f0 != 1) chk($sformatf("vec%0d_s0_paddr", k), s0_paddr, tv[k].pa0);
            end
            if (tv[k].s.s1) begin
                chk($sformatf("vec%0d_s1_fault", k), fcode(s1_refill, s1_invalid, s1_modified), tv[k].f1);
                if (tv[k].f1 != 1) chk($sformatf("vec%0d_s1_paddr", k), s1_paddr, tv[k].pa1);
            end
            if (tv[k].s.p) chk($sformatf("vec%0d_tlbp_index", k), tlbp_index, tv[k].pidx);
            if (tv[k].s.r) chk($sformatf("vec%0d_tlbr_entry", k), tlbr_entry, tv[k].rent);
        end

        // Valid pulses drop and data holds on an idle cycle.
        step(idle());
        chk("hold_tlbr_entry", tlbr_entry, e3c);
        chk("hold_tlbp_index", tlbp_index, 32'h0000_0001);

        for (int n = 0; n < 400; n++) begin
            int r0, r1;
            s = idle();
            s.we   = ($urandom % 4 == 0);
            s.widx = 4'($urandom);
            s.went = {19'($urandom % 4), 8'($urandom % 4), 1'($urandom % 4 == 0),
                      25'($urandom), 25'($urandom)};
            r0 = $urandom % 8;
            r1 = $urandom % 8;
            s.s0  = 1'($urandom);
            s.va0 = {19'($urandom % 4), 13'($urandom)};
            if (r0 == 0) s.va0[31:29] = 3'b100;
            if (r0 == 1) s.va0[31:29] = 3'b101;
            if (r0 == 2) s.va0[31:29] = 3'b110;
            s.as0 = 8'($urandom % 4);
            s.s1  = 1'($urandom);
            s.va1 = {19'($urandom % 4), 13'($urandom)};
            if (r1 == 0) s.va1[31:29] = 3'b100;
            if (r1 == 1) s.va1[31:29] = 3'b101;
            s.as1 = 8'($urandom % 4);
            s.st1 = 1'($urandom);
            s.p   = 1'($urandom);
            s.hi  = {19'($urandom % 4), 5'($urandom), 8'($urandom % 4)};
            s.r   = 1'($urandom);
            s.ridx = 4'($urandom);
            step(s);
        end

        // Reset lands while a probe and a lookup are in flight: no response emerges.
        s = idle();
        s.p = 1; s.hi = 32'h0000_2005;
        s.s0 = 1; s.va0 = 32'h0000_2ABC; s.as0 = 8'd5;
        drive(s);
        #2 rst_n = 1'b0;
        @(posedge clk);
        drive(idle());
        @(negedge clk);
        chk("rstfly_tlbp_valid", tlbp_valid, 1'b0);
        chk("rstfly_s0_valid", s0_valid, 1'b0);
        chk("rstfly_tlbp_index", tlbp_index, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) m_tlb[i] = '0;
        @(negedge clk);
        s = idle();
        s.s0 = 1; s.va0 = 32'h0000_2ABC; s.as0 = 8'd5;
        s.r = 1; s.ridx = 4'd3;
        step(s);
        chk("post_rst_refill", s0_refill, 1'b1);
        chk("post_rst_entry", tlbr_entry, 78'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
